// File: rtl/rs_pkg.sv
// Shared types for the ALU reservation station: default sizes, ALU opcodes,
// the per-slot entry layout and the issue register layout.
package rs_pkg;

  localparam int unsigned RS_ENTRIES = 4;
  localparam int unsigned RS_TAG_W   = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned OP_W       = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 5'b00000,
    OP_SUB = 5'b00001,
    OP_AND = 5'b00010,
    OP_OR  = 5'b00011,
    OP_SLL = 5'b00100,
    OP_SRA = 5'b00101
  } alu_op_e;

  typedef struct packed {
    logic                rdy;
    logic [RS_TAG_W-1:0] tag;
    logic [DATA_W-1:0]   val;
  } rs_operand_t;

  typedef struct packed {
    logic                valid;
    logic [OP_W-1:0]     opcode;
    logic [OP_W-1:0]     shamt;
    logic [RS_TAG_W-1:0] dest_tag;
    rs_operand_t         a;
    rs_operand_t         b;
  } rs_entry_t;

  typedef struct packed {
    logic                valid;
    logic [OP_W-1:0]     opcode;
    logic [OP_W-1:0]     shamt;
    logic [RS_TAG_W-1:0] dest_tag;
    logic [DATA_W-1:0]   a_val;
    logic [DATA_W-1:0]   b_val;
  } rs_issue_t;

  // A broadcast only wakes an operand that is still waiting on that tag.
  function automatic logic tag_hit(input logic                cdb_valid,
                                   input logic [RS_TAG_W-1:0] cdb_tag,
                                   input rs_operand_t         opnd);
    return cdb_valid && !opnd.rdy && (opnd.tag == cdb_tag);
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the reservation station.
// slave is the station's view, master is the surrounding pipeline's view.
interface alu_reservation_station_if #(
  parameter int unsigned TAG_W = rs_pkg::RS_TAG_W
) ();

  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [4:0]       dispatch_opcode;
  logic [4:0]       dispatch_shamt;
  logic [TAG_W-1:0] dispatch_dest_tag;
  logic             dispatch_a_rdy;
  logic             dispatch_b_rdy;
  logic [31:0]      dispatch_a_val;
  logic [31:0]      dispatch_b_val;
  logic [TAG_W-1:0] dispatch_a_tag;
  logic [TAG_W-1:0] dispatch_b_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             issue_valid;
  logic             issue_ready;
  logic [4:0]       issue_opcode;
  logic [4:0]       issue_shamt;
  logic [31:0]      issue_operand_a;
  logic [31:0]      issue_operand_b;
  logic [TAG_W-1:0] issue_dest_tag;

  modport slave (
    input  dispatch_valid, dispatch_opcode, dispatch_shamt, dispatch_dest_tag,
           dispatch_a_rdy, dispatch_b_rdy, dispatch_a_val, dispatch_b_val,
           dispatch_a_tag, dispatch_b_tag,
           cdb_valid, cdb_tag, cdb_value,
           issue_ready,
    output dispatch_ready,
           issue_valid, issue_opcode, issue_shamt,
           issue_operand_a, issue_operand_b, issue_dest_tag
  );

  modport master (
    output dispatch_valid, dispatch_opcode, dispatch_shamt, dispatch_dest_tag,
           dispatch_a_rdy, dispatch_b_rdy, dispatch_a_val, dispatch_b_val,
           dispatch_a_tag, dispatch_b_tag,
           cdb_valid, cdb_tag, cdb_value,
           issue_ready,
    input  dispatch_ready,
           issue_valid, issue_opcode, issue_shamt,
           issue_operand_a, issue_operand_b, issue_dest_tag
  );

endinterface

// File: rtl/rs_operand_wakeup.sv
// One operand's CDB tag compare and capture. Serves both as wakeup for a
// stored operand and as the dispatch-time bypass for a newly written one.
module rs_operand_wakeup
  import rs_pkg::*;
(
  input  logic                slot_valid_i,
  input  rs_operand_t         opnd_i,
  input  logic                cdb_valid_i,
  input  logic [RS_TAG_W-1:0] cdb_tag_i,
  input  logic [DATA_W-1:0]   cdb_value_i,
  output rs_operand_t         opnd_o
);

  logic hit;

  assign hit = slot_valid_i && tag_hit(cdb_valid_i, cdb_tag_i, opnd_i);

  always_comb begin
    // NOTE: the output gets its full default first, so no path through this
    // block leaves it unassigned and no latch can be inferred.
    opnd_o = opnd_i;
    if (hit) begin
      opnd_o.rdy = 1'b1;
      opnd_o.val = cdb_value_i;
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Collapsing, age-ordered reservation station in front of the integer ALU.
// Holds renamed instructions until both operands are ready, issues oldest-first.
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned ENTRIES = RS_ENTRIES,
  parameter int unsigned TAG_W   = RS_TAG_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  alu_reservation_station_if.slave  rs_if,
  output logic [$clog2(ENTRIES):0]  occupancy
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ENTRIES);

  rs_entry_t        ent_q  [ENTRIES];
  rs_entry_t        ent_d  [ENTRIES];
  rs_entry_t        src    [ENTRIES];
  rs_operand_t      wake_a [ENTRIES];
  rs_operand_t      wake_b [ENTRIES];
  logic [CNT_W-1:0] count_q, count_d;
  rs_issue_t        issue_q, issue_d;

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                issue_load;
  logic                do_disp;
  logic [CNT_W-1:0]    base_cnt;
  rs_entry_t           disp_entry;
  logic [RS_TAG_W-1:0] cdb_tag;

  assign cdb_tag = RS_TAG_W'(rs_if.cdb_tag);

  // Select uses registered readiness only; a same-cycle wakeup is not seen.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].a.rdy && ent_q[i].b.rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_load           = sel_found && (!issue_q.valid || rs_if.issue_ready);
  assign rs_if.dispatch_ready = (count_q != FULL);
  assign do_disp              = rs_if.dispatch_valid && rs_if.dispatch_ready;
  assign base_cnt             = count_q - CNT_W'(issue_load);

  always_comb begin
    disp_entry          = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.opcode   = rs_if.dispatch_opcode;
    disp_entry.shamt    = rs_if.dispatch_shamt;
    disp_entry.dest_tag = RS_TAG_W'(rs_if.dispatch_dest_tag);
    disp_entry.a.rdy    = rs_if.dispatch_a_rdy;
    disp_entry.a.tag    = RS_TAG_W'(rs_if.dispatch_a_tag);
    disp_entry.a.val    = rs_if.dispatch_a_val;
    disp_entry.b.rdy    = rs_if.dispatch_b_rdy;
    disp_entry.b.tag    = RS_TAG_W'(rs_if.dispatch_b_tag);
    disp_entry.b.val    = rs_if.dispatch_b_val;
  end

  // Collapse above the removed slot, then place a new entry at the first free
  // slot of the collapsed queue so the queue stays dense.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      src[i] = ent_q[i];
      if (issue_load && (IDX_W'(i) >= sel_idx)) begin
        src[i] = (i < ENTRIES - 1) ? ent_q[(i + 1) % ENTRIES] : '0;
      end
      if (do_disp && (CNT_W'(i) == base_cnt)) begin
        src[i] = disp_entry;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    rs_operand_wakeup u_wake_a (
      .slot_valid_i (src[g].valid),
      .opnd_i       (src[g].a),
      .cdb_valid_i  (rs_if.cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_value_i  (rs_if.cdb_value),
      .opnd_o       (wake_a[g])
    );

    rs_operand_wakeup u_wake_b (
      .slot_valid_i (src[g].valid),
      .opnd_i       (src[g].b),
      .cdb_valid_i  (rs_if.cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_value_i  (rs_if.cdb_value),
      .opnd_o       (wake_b[g])
    );
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i]   = src[i];
      ent_d[i].a = wake_a[i];
      ent_d[i].b = wake_b[i];
    end
    count_d = base_cnt + CNT_W'(do_disp);
  end

  // A stalled issue register keeps its outputs; once accepted with nothing to
  // replace it, only valid drops.
  always_comb begin
    issue_d = issue_q;
    if (issue_load) begin
      issue_d.valid    = 1'b1;
      issue_d.opcode   = ent_q[sel_idx].opcode;
      issue_d.shamt    = ent_q[sel_idx].shamt;
      issue_d.dest_tag = ent_q[sel_idx].dest_tag;
      issue_d.a_val    = ent_q[sel_idx].a.val;
      issue_d.b_val    = ent_q[sel_idx].b.val;
    end else if (rs_if.issue_ready) begin
      issue_d.valid = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the slot payloads are reset along with the valid bits; the array
      // is tiny and this keeps every issue field at a known value after reset.
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
      issue_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i].valid <= 1'b0;
      end
      count_q       <= '0;
      issue_q.valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
      issue_q <= issue_d;
    end
  end

  assign rs_if.issue_valid     = issue_q.valid;
  assign rs_if.issue_opcode    = issue_q.opcode;
  assign rs_if.issue_shamt     = issue_q.shamt;
  assign rs_if.issue_operand_a = issue_q.a_val;
  assign rs_if.issue_operand_b = issue_q.b_val;
  assign rs_if.issue_dest_tag  = TAG_W'(issue_q.dest_tag);
  assign occupancy             = count_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected issues are queued at
// dispatch and compared whenever the ALU side accepts an instruction.
module tb_alu_reservation_station;
  import rs_pkg::*;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [5:0]  dt;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [2:0] occupancy;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t exp_q[$];

  alu_reservation_station_if #(.TAG_W(6)) rs_if ();

  alu_reservation_station #(.ENTRIES(4), .TAG_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .rs_if     (rs_if),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_dispatch(input logic [4:0] op, input logic [4:0] sh, input logic [5:0] dt,
                                input logic ar, input logic [5:0] at, input logic [31:0] av,
                                input logic br, input logic [5:0] bt, input logic [31:0] bv);
    rs_if.dispatch_valid    = 1'b1;
    rs_if.dispatch_opcode   = op;
    rs_if.dispatch_shamt    = sh;
    rs_if.dispatch_dest_tag = dt;
    rs_if.dispatch_a_rdy    = ar;
    rs_if.dispatch_a_tag    = at;
    rs_if.dispatch_a_val    = av;
    rs_if.dispatch_b_rdy    = br;
    rs_if.dispatch_b_tag    = bt;
    rs_if.dispatch_b_val    = bv;
  endtask

  task automatic idle_dispatch();
    rs_if.dispatch_valid = 1'b0;
  endtask

  task automatic drive_cdb(input logic [5:0] tag, input logic [31:0] val);
    rs_if.cdb_valid = 1'b1;
    rs_if.cdb_tag   = tag;
    rs_if.cdb_value = val;
  endtask

  task automatic idle_cdb();
    rs_if.cdb_valid = 1'b0;
  endtask

  task automatic expect_issue(input logic [4:0] op, input logic [4:0] sh, input logic [5:0] dt,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.op = op;
    e.sh = sh;
    e.dt = dt;
    e.a  = a;
    e.b  = b;
    exp_q.push_back(e);
  endtask

  // Issue handshake completes at the next rising edge; sample mid-cycle.
  always @(negedge clock) begin
    if (!reset && rs_if.issue_valid && rs_if.issue_ready) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 32'(rs_if.issue_dest_tag), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_opcode", 32'(rs_if.issue_opcode), 32'(e.op));
        check("issue_shamt",  32'(rs_if.issue_shamt),  32'(e.sh));
        check("issue_dest",   32'(rs_if.issue_dest_tag), 32'(e.dt));
        check("issue_op_a",   rs_if.issue_operand_a, e.a);
        check("issue_op_b",   rs_if.issue_operand_b, e.b);
      end
    end
  end

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    rs_if.dispatch_valid    = 1'b0;
    rs_if.dispatch_opcode   = '0;
    rs_if.dispatch_shamt    = '0;
    rs_if.dispatch_dest_tag = '0;
    rs_if.dispatch_a_rdy    = 1'b0;
    rs_if.dispatch_a_tag    = '0;
    rs_if.dispatch_a_val    = '0;
    rs_if.dispatch_b_rdy    = 1'b0;
    rs_if.dispatch_b_tag    = '0;
    rs_if.dispatch_b_val    = '0;
    rs_if.cdb_valid         = 1'b0;
    rs_if.cdb_tag           = '0;
    rs_if.cdb_value         = '0;
    rs_if.issue_ready       = 1'b1;
    step();
    step();
    reset = 1'b0;

    check("rst_issue_valid", 32'(rs_if.issue_valid), 32'd0);
    check("rst_issue_opcode", 32'(rs_if.issue_opcode), 32'd0);
    check("rst_issue_shamt", 32'(rs_if.issue_shamt), 32'd0);
    check("rst_issue_a", rs_if.issue_operand_a, 32'd0);
    check("rst_issue_b", rs_if.issue_operand_b, 32'd0);
    check("rst_issue_dest", 32'(rs_if.issue_dest_tag), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_dispatch_ready", 32'(rs_if.dispatch_ready), 32'd1);

    // Both operands ready at dispatch: two cycles to issue.
    drive_dispatch(OP_ADD, 5'd0, 6'h11, 1'b1, 6'h0, 32'd5, 1'b1, 6'h0, 32'd7);
    expect_issue(OP_ADD, 5'd0, 6'h11, 32'd5, 32'd7);
    step();
    idle_dispatch();
    check("t1_n1_valid", 32'(rs_if.issue_valid), 32'd0);
    check("t1_n1_occ", 32'(occupancy), 32'd1);
    step();
    check("t1_n2_valid", 32'(rs_if.issue_valid), 32'd1);
    check("t1_n2_occ", 32'(occupancy), 32'd0);
    step();
    check("t1_drop", 32'(rs_if.issue_valid), 32'd0);

    // A waits on tag 9, woken three cycles after dispatch.
    drive_dispatch(OP_SUB, 5'd2, 6'h12, 1'b0, 6'd9, 32'h0BAD_0BAD, 1'b1, 6'h0, 32'd3);
    expect_issue(OP_SUB, 5'd2, 6'h12, 32'd10, 32'd3);
    step();
    idle_dispatch();
    step();
    step();
    check("t2_waiting", 32'(rs_if.issue_valid), 32'd0);
    drive_cdb(6'd9, 32'd10);
    step();
    idle_cdb();
    check("t2_cdb_n1", 32'(rs_if.issue_valid), 32'd0);
    step();
    check("t2_cdb_n2", 32'(rs_if.issue_valid), 32'd1);
    step();

    // Dispatch-time bypass from the CDB.
    drive_dispatch(OP_AND, 5'd1, 6'h13, 1'b0, 6'd4, 32'hDEAD_BEEF, 1'b1, 6'h0, 32'h1234);
    drive_cdb(6'd4, 32'hFFFF_FFFF);
    expect_issue(OP_AND, 5'd1, 6'h13, 32'hFFFF_FFFF, 32'h1234);
    step();
    idle_dispatch();
    idle_cdb();
    check("t3_n1", 32'(rs_if.issue_valid), 32'd0);
    step();
    check("t3_n2", 32'(rs_if.issue_valid), 32'd1);
    step();

    // Fill: oldest entry blocked on tag 20 (both operands), younger ones ready.
    rs_if.issue_ready = 1'b0;
    drive_dispatch(OP_OR, 5'd0, 6'h20, 1'b0, 6'd20, 32'h0, 1'b0, 6'd20, 32'h0);
    step();
    drive_dispatch(OP_ADD, 5'd0, 6'h21, 1'b1, 6'h0, 32'd100, 1'b1, 6'h0, 32'd1);
    expect_issue(OP_ADD, 5'd0, 6'h21, 32'd100, 32'd1);
    step();
    drive_dispatch(OP_SUB, 5'd0, 6'h22, 1'b1, 6'h0, 32'd200, 1'b1, 6'h0, 32'd2);
    expect_issue(OP_SUB, 5'd0, 6'h22, 32'd200, 32'd2);
    step();
    drive_dispatch(OP_SLL, 5'd4, 6'h23, 1'b1, 6'h0, 32'd300, 1'b1, 6'h0, 32'd3);
    expect_issue(OP_SLL, 5'd4, 6'h23, 32'd300, 32'd3);
    step();
    drive_dispatch(OP_SRA, 5'd31, 6'h24, 1'b1, 6'h0, 32'h8000_0000, 1'b1, 6'h0, 32'd4);
    expect_issue(OP_SRA, 5'd31, 6'h24, 32'h8000_0000, 32'd4);
    step();
    drive_dispatch(OP_ADD, 5'd7, 6'h2F, 1'b1, 6'h0, 32'd9, 1'b1, 6'h0, 32'd9);
    check("t4_full_ready", 32'(rs_if.dispatch_ready), 32'd0);
    check("t4_full_occ", 32'(occupancy), 32'd4);
    step();
    idle_dispatch();
    check("t4_ignored_occ", 32'(occupancy), 32'd4);
    check("t4_hold_dest", 32'(rs_if.issue_dest_tag), 32'h21);
    expect_issue(OP_OR, 5'd0, 6'h20, 32'h55AA_00FF, 32'h55AA_00FF);
    rs_if.issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_back_to_back", 32'(rs_if.issue_valid), 32'd1);
    end
    step();
    check("t4_blocked_valid", 32'(rs_if.issue_valid), 32'd0);
    check("t4_blocked_occ", 32'(occupancy), 32'd1);
    drive_cdb(6'd20, 32'h55AA_00FF);
    step();
    idle_cdb();
    check("t4_wake_n1", 32'(rs_if.issue_valid), 32'd0);
    step();
    check("t4_wake_n2", 32'(rs_if.issue_valid), 32'd1);
    check("t4_wake_occ", 32'(occupancy), 32'd0);
    step();

    // Stall with two ready entries, then release.
    rs_if.issue_ready = 1'b0;
    drive_dispatch(OP_ADD, 5'd3, 6'h31, 1'b1, 6'h0, 32'd11, 1'b1, 6'h0, 32'd22);
    expect_issue(OP_ADD, 5'd3, 6'h31, 32'd11, 32'd22);
    step();
    drive_dispatch(OP_SUB, 5'd5, 6'h32, 1'b1, 6'h0, 32'd33, 1'b1, 6'h0, 32'd44);
    expect_issue(OP_SUB, 5'd5, 6'h32, 32'd33, 32'd44);
    step();
    idle_dispatch();
    for (int k = 0; k < 3; k++) begin
      check("t5_stall_valid", 32'(rs_if.issue_valid), 32'd1);
      check("t5_stall_a", rs_if.issue_operand_a, 32'd11);
      check("t5_stall_occ", 32'(occupancy), 32'd1);
      step();
    end
    rs_if.issue_ready = 1'b1;
    step();
    check("t5_release_valid", 32'(rs_if.issue_valid), 32'd1);
    check("t5_release_occ", 32'(occupancy), 32'd0);
    step();
    check("t5_drained", 32'(rs_if.issue_valid), 32'd0);

    // Flush with three queued and a held issue, plus same-cycle dispatch and CDB.
    rs_if.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(OP_AND, 5'd0, 6'(6'h38 + k), 1'b1, 6'h0, 32'(k), 1'b1, 6'h0, 32'(k));
      step();
    end
    idle_dispatch();
    check("t6_pre_valid", 32'(rs_if.issue_valid), 32'd1);
    check("t6_pre_occ", 32'(occupancy), 32'd3);
    flush = 1'b1;
    drive_dispatch(OP_OR, 5'd0, 6'h3E, 1'b1, 6'h0, 32'd1, 1'b1, 6'h0, 32'd1);
    drive_cdb(6'd1, 32'd77);
    step();
    flush = 1'b0;
    idle_dispatch();
    idle_cdb();
    check("t6_flush_valid", 32'(rs_if.issue_valid), 32'd0);
    check("t6_flush_occ", 32'(occupancy), 32'd0);
    check("t6_flush_ready", 32'(rs_if.dispatch_ready), 32'd1);
    step();
    check("t6_quiet", 32'(rs_if.issue_valid), 32'd0);

    rs_if.issue_ready = 1'b1;
    drive_dispatch(OP_SLL, 5'd3, 6'h3F, 1'b1, 6'h0, 32'd1, 1'b1, 6'h0, 32'd0);
    expect_issue(OP_SLL, 5'd3, 6'h3F, 32'd1, 32'd0);
    step();
    idle_dispatch();
    step();
    check("t6_after_flush", 32'(rs_if.issue_valid), 32'd1);
    step();
    step();

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Four-entry reservation station that sits directly upstream of the integer ALU in the out-of-order core. It accepts renamed ALU instructions from dispatch and holds them until both source operands are available. Operands arrive either at dispatch or by snooping the common data bus (CDB). Each cycle it selects the oldest ready entry and presents opcode, shift amount and operands to the ALU through a registered valid/ready issue port.

## Interface
Parameters:
- ENTRIES, 4, number of station slots (power of two, ≥2)
- TAG_W, 6, ROB/physical tag width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous squash of all entries and the issue register
- dispatch_valid  in  1  dispatch offers an instruction
- dispatch_ready  out  1  station can accept (registered count < ENTRIES)
- dispatch_opcode  in  5  ALU opcode
- dispatch_shamt  in  5  shift amount
- dispatch_dest_tag  in  TAG_W  destination tag
- dispatch_a_rdy, dispatch_b_rdy  in  1 each  operand value valid at dispatch
- dispatch_a_val, dispatch_b_val  in  32 each  operand value if ready
- dispatch_a_tag, dispatch_b_tag  in  TAG_W each  producer tag if not ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  32  broadcast result
- issue_valid  out  1  issue register holds an instruction
- issue_ready  in  1  ALU stage accepts
- issue_opcode, issue_shamt  out  5 each
- issue_operand_a, issue_operand_b  out  32 each
- issue_dest_tag  out  TAG_W
- occupancy  out  $clog2(ENTRIES)+1  valid entries in the queue (excludes issue register)

## Operation
- Queue is collapsing and age-ordered: slot 0 is oldest. Dispatch writes slot [count].
- Entry fields: valid, opcode, shamt, dest_tag, a_rdy/a_tag/a_val, b_rdy/b_tag/b_val.
- Wakeup: when cdb_valid is high, every valid entry with a non-ready operand whose tag equals cdb_tag captures cdb_value and sets rdy at the clock edge. The A and B operands of one entry may both match.
- Dispatch bypass: when an operand is dispatched not-ready and its tag matches the CDB in the same cycle, it is written as ready with cdb_value.
- Select: the lowest-index entry with a_rdy & b_rdy. The ready state used is the registered state; a same-cycle CDB wakeup is not visible to select.
- Issue register load condition: (!issue_valid | issue_ready) & a ready entry exists. On load, the selected entry is copied into the issue register and removed, and younger entries shift down one slot.
- A simultaneous dispatch and removal writes the new entry at slot count−1 so the queue stays dense.
- If issue_valid & !issue_ready, the issue register holds its outputs stable and no select occurs.
- dispatch_ready depends on the registered count only. A slot freed in the same cycle is not offered.
- flush (or reset) clears all valid bits and issue_valid, and overrides a same-cycle dispatch and CDB.

## Timing
- Reset values: issue_valid=0, all issue data=0, occupancy=0, dispatch_ready=1.
- Dispatch with both operands ready in cycle N → issue_valid in cycle N+2 (N+1 queued, selected at end of N+1).
- CDB wakeup in cycle N → entry selectable in N+1 → issue_valid in N+2.
- Back-to-back: with issue_ready held high, one instruction issues per cycle.
- Full (count==ENTRIES): dispatch_ready=0; an asserted dispatch_valid is ignored.
- Empty with no ready entry: issue_valid drops after the current instruction is accepted.

## Structure
- Shared package rs_pkg holds:
  - TAG_W and ENTRIES defaults
  - the ALU opcode constants (ADD=00000, SUB=00001, AND=00010, OR=00011, SLL=00100, SRA=00101)
  - the entry field layout
- One sub-module, rs_operand_wakeup: a single operand's tag compare, bypass and capture logic. It is instantiated twice per slot.

## Test plan
- Reset, then dispatch ADD with A=5 and B=7 both ready → issue_valid 2 cycles later; opcode=00000, operands 5/7, dest_tag preserved.
- Dispatch SUB with A waiting on tag 9 and B=3 ready; 3 cycles later CDB tag=9 value=10 → issue 2 cycles after the CDB, operand_a=10.
- Dispatch with a_tag=4 while the CDB broadcasts tag 4 value 0xFFFF_FFFF in the same cycle → operand captured via bypass; issues with operand_a=0xFFFF_FFFF.
- Fill 4 entries, with entry 0 blocked and entries 1–3 ready → dispatch_ready=0; issue order is 1, 2, 3. After the CDB wakes entry 0, it issues next.
- Hold issue_ready=0 with 2 ready entries → issue outputs stable and occupancy=1. On release, both issue on consecutive cycles.
- Flush with 3 entries queued and issue_valid=1, plus a same-cycle dispatch → next cycle issue_valid=0, occupancy=0, dispatch_ready=1.
